// File: rtl/fifo_retx_pkg.sv
// Shared definitions for the retransmit FIFO: link-layer command codes and
// elaboration-time helpers for sizing and pointer arithmetic.
package fifo_retx_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_ACK  = 2'd1,
    CMD_NACK = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Raw pointer distance; the caller truncates to the pointer width, which
  // makes the subtraction modular across the wrap bit.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/fifo_retx_ram.sv
// Simple dual-port storage for the retransmit FIFO: synchronous write port,
// asynchronous read port so the head word falls through without a bubble.
module fifo_retx_ram
  import fifo_retx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_retx_buffer.sv
// Transmit FIFO that holds words until the link layer ACKs them; a NACK rewinds
// the read pointer to the oldest unacknowledged word and counts the retry.
module fifo_retx_buffer
  import fifo_retx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_RETRY  = 3,
  localparam int ADDR_WIDTH = clog2(FIFO_DEPTH),
  localparam int PW         = ADDR_WIDTH + 1,
  localparam int RW         = clog2(MAX_RETRY + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd,
  output logic                  full,
  output logic                  empty,
  output logic [PW-1:0]         level,
  output logic [PW-1:0]         unacked,
  output logic [RW-1:0]         retry_cnt,
  output logic                  retry_err
);

  localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
  localparam logic [RW-1:0] MAX_CNT  = RW'(MAX_RETRY);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] ack_ptr_q, ack_ptr_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          retry_err_q, retry_err_d;

  logic wr_fire, rd_fire, is_ack, is_nack;

  assign level    = PW'(ptr_diff(32'(wr_ptr_q), 32'(ack_ptr_q)));
  assign unacked  = PW'(ptr_diff(32'(rd_ptr_q), 32'(ack_ptr_q)));
  assign full     = (level == DEPTH_P);
  assign empty    = (rd_ptr_q == wr_ptr_q);
  assign s_tready = ~full;
  assign m_tvalid = ~empty;

  assign wr_fire = s_tvalid & s_tready;
  assign rd_fire = m_tvalid & m_tready;
  assign is_ack  = cmd_valid & (cmd == CMD_ACK);
  assign is_nack = cmd_valid & (cmd == CMD_NACK);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ack_ptr_d   = ack_ptr_q;
    retry_cnt_d = retry_cnt_q;
    retry_err_d = retry_err_q;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    // A rewind overrides a concurrent read: that word goes out again.
    if (is_nack) begin
      rd_ptr_d = ack_ptr_q;
    end else if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Commit only what was sent before this edge; a same-cycle read joins the next frame.
    if (is_ack) begin
      ack_ptr_d   = rd_ptr_q;
      retry_cnt_d = '0;
    end

    if (is_nack) begin
      if (retry_cnt_q != MAX_CNT) begin
        retry_cnt_d = retry_cnt_q + RW'(1);
      end
      if (retry_cnt_d == MAX_CNT) begin
        retry_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ack_ptr_q   <= '0;
      retry_cnt_q <= '0;
      retry_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ack_ptr_q   <= ack_ptr_d;
      retry_cnt_q <= retry_cnt_d;
      retry_err_q <= retry_err_d;
    end
  end

  assign retry_cnt = retry_cnt_q;
  assign retry_err = retry_err_q;

  fifo_retx_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (s_tdata),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (m_tdata)
  );

endmodule
